// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - multi-cycle instruction sequencer driving the pc unit
//
// Purpose:
//   Fetches one instruction at a time over a req/ack handshake, walks it
//   through DECODE/EXEC/MEM/WB and issues exactly one non-HOLD pc_op per
//   retired instruction. Supplies the pc unit's im1/im2/zero/great inputs.
//
// Ports:
//   clk          clock, rising edge
//   rest         asynchronous active-low reset
//   imem_req     instruction fetch request (high in FETCH)
//   imem_ack     fetch data valid
//   imem_rdata   instruction word
//   alu_zero     ALU zero flag, sampled in EXEC
//   alu_great    ALU greater-than-zero flag, sampled in EXEC
//   dmem_req     data memory request (high in MEM)
//   dmem_we      store qualifier for dmem_req
//   dmem_ack     data access complete
//   reg_we       register-file write strobe (one cycle in WB)
//   instr        latched current instruction
//   im1          instr[15:0]
//   im2          instr[25:0]
//   zero         registered alu_zero
//   great        registered alu_great
//   pc_op        PC command: HOLD=0 NEXT=1 J=2 JAL=3 JR=4 BZ=5 BG=6
//   halted       sequencer stopped by the halt opcode
//   illegal      sticky unknown-opcode flag
//   retired      count of completed instructions

module pc_seq #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rest,
  output logic                   imem_req,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   alu_zero,
  input  logic                   alu_great,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  output logic                   reg_we,
  output logic [31:0]            instr,
  output logic [15:0]            im1,
  output logic [25:0]            im2,
  output logic                   zero,
  output logic                   great,
  output logic [3:0]             pc_op,
  output logic                   halted,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] retired
);

  localparam logic [3:0] PC_OP_HOLD = 4'd0;
  localparam logic [3:0] PC_OP_NEXT = 4'd1;
  localparam logic [3:0] PC_OP_J    = 4'd2;
  localparam logic [3:0] PC_OP_JAL  = 4'd3;
  localparam logic [3:0] PC_OP_JR   = 4'd4;
  localparam logic [3:0] PC_OP_BZ   = 4'd5;
  localparam logic [3:0] PC_OP_BG   = 4'd6;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BGTZ  = 6'b000111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_HALT  = 6'b111111;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
  } state_t;

  state_t state, state_nxt;

  // Instruction classification works off the latched word, so every
  // output below is derived from registered state only.
  logic [5:0] opcode;
  logic [5:0] funct;
  logic is_rtype, is_jr, is_addi, is_jal, is_lw, is_sw;
  logic is_beq, is_bgtz, is_j, is_halt, is_known;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign is_rtype = (opcode == OPC_RTYPE);
  assign is_jr    = is_rtype && (funct == FUNCT_JR);
  assign is_addi  = (opcode == OPC_ADDI);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_lw    = (opcode == OPC_LW);
  assign is_sw    = (opcode == OPC_SW);
  assign is_beq   = (opcode == OPC_BEQ);
  assign is_bgtz  = (opcode == OPC_BGTZ);
  assign is_j     = (opcode == OPC_J);
  assign is_halt  = (opcode == OPC_HALT);
  assign is_known = is_rtype | is_addi | is_jal | is_lw | is_sw |
                    is_beq | is_bgtz | is_j | is_halt;

  assign im1 = instr[15:0];
  assign im2 = instr[25:0];

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      instr   <= 32'd0;
      zero    <= 1'b0;
      great   <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == S_EXEC) begin
        zero  <= alu_zero;
        great <= alu_great;
      end
      if (state == S_DECODE && !is_known) begin
        illegal <= 1'b1;
      end
      // halt passes through PCUPD only to park the PC; it is not retired
      if (state == S_PCUPD && !is_halt) begin
        retired <= retired + {{(INSTR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    pc_op     = PC_OP_HOLD;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = is_halt ? S_PCUPD : S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else if ((is_rtype && !is_jr) || is_addi || is_jal) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_PCUPD;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ack) begin
          state_nxt = is_lw ? S_WB : S_PCUPD;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        state_nxt = S_PCUPD;
      end
      S_PCUPD: begin
        state_nxt = is_halt ? S_HALT : S_FETCH;
        if (is_halt) begin
          pc_op = PC_OP_HOLD;
        end else if (is_beq) begin
          pc_op = PC_OP_BZ;
        end else if (is_bgtz) begin
          pc_op = PC_OP_BG;
        end else if (is_j) begin
          pc_op = PC_OP_J;
        end else if (is_jal) begin
          pc_op = PC_OP_JAL;
        end else if (is_jr) begin
          pc_op = PC_OP_JR;
        end else begin
          pc_op = PC_OP_NEXT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - table-driven bench for pc_seq

module tb_pc_seq;

  localparam logic [3:0] OP_HOLD = 4'd0;
  localparam logic [3:0] OP_NEXT = 4'd1;
  localparam logic [3:0] OP_J    = 4'd2;
  localparam logic [3:0] OP_JAL  = 4'd3;
  localparam logic [3:0] OP_JR   = 4'd4;
  localparam logic [3:0] OP_BZ   = 4'd5;
  localparam logic [3:0] OP_BG   = 4'd6;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'hDEADBEEF;
  logic        alu_zero = 1'b0;
  logic        alu_great = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        reg_we;
  logic [31:0] instr;
  logic [15:0] im1;
  logic [25:0] im2;
  logic        zero;
  logic        great;
  logic [3:0]  pc_op;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pc_seq #(.INSTR_CNT_W(32)) dut (
    .clk(clk), .rest(rest),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_zero(alu_zero), .alu_great(alu_great),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .instr(instr), .im1(im1), .im2(im2),
    .zero(zero), .great(great), .pc_op(pc_op),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  typedef struct {
    logic [31:0] word;
    int          iw;     // imem wait cycles before ack
    int          dw;     // dmem wait cycles before ack
    logic        az;
    logic        ag;
    int          cyc;    // FETCH..PCUPD inclusive
    logic [3:0]  op;
    int          we;     // reg_we cycles
    int          dreq;   // dmem_req cycles
    logic        dwe;
    logic        ill;
  } vec_t;

  vec_t vt[11];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drives one instruction through the sequencer and checks it. The ALU
  // flags carry the wanted value only in the EXEC cycle (two cycles after
  // the fetch ack) so a capture in any other state shows up.
  task automatic run_instr(input vec_t v, input int idx, input int exp_ret);
    int         cyc = 0;
    int         iw = v.iw;
    int         dw = v.dw;
    int         since_ack = -1;
    int         we_cnt = 0;
    int         dreq_cnt = 0;
    logic       started = 1'b0;
    logic       done = 1'b0;
    logic       dwe_or = 1'b0;
    logic [3:0] op_seen = OP_HOLD;
    logic       z_at = 1'b0;
    logic       g_at = 1'b0;
    logic       ill_at = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      @(negedge clk);
      imem_ack   = 1'b0;
      dmem_ack   = 1'b0;
      imem_rdata = 32'hDEADBEEF;
      alu_zero   = ~v.az;
      alu_great  = ~v.ag;
      if (!started && imem_req) begin
        started = 1'b1;
        chk($sformatf("v%0d retired", idx), retired, exp_ret);
      end
      if (started) cyc++;
      if (since_ack >= 0) since_ack++;
      if (since_ack == 2) begin
        alu_zero  = v.az;
        alu_great = v.ag;
      end
      if (imem_req) begin
        if (iw > 0) iw--;
        else begin
          imem_ack   = 1'b1;
          imem_rdata = v.word;
          since_ack  = 0;
        end
      end
      if (dmem_req) begin
        dreq_cnt++;
        dwe_or = dwe_or | dmem_we;
        if (dw > 0) dw--;
        else dmem_ack = 1'b1;
      end
      if (reg_we) we_cnt++;
      if (pc_op != OP_HOLD) begin
        op_seen = pc_op;
        z_at    = zero;
        g_at    = great;
        ill_at  = illegal;
        done    = 1'b1;
      end
    end
    chk($sformatf("v%0d completed", idx), done, 1'b1);
    chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d pc_op", idx), op_seen, v.op);
    chk($sformatf("v%0d reg_we", idx), we_cnt, v.we);
    chk($sformatf("v%0d dmem_req", idx), dreq_cnt, v.dreq);
    chk($sformatf("v%0d dmem_we", idx), dwe_or, v.dwe);
    chk($sformatf("v%0d zero", idx), z_at, v.az);
    chk($sformatf("v%0d great", idx), g_at, v.ag);
    chk($sformatf("v%0d illegal", idx), ill_at, v.ill);
    chk($sformatf("v%0d instr", idx), instr, v.word);
    chk($sformatf("v%0d im1", idx), im1, v.word[15:0]);
    chk($sformatf("v%0d im2", idx), im2, v.word[25:0]);
  endtask

  initial begin
    //          word          iw dw az    ag    cyc op       we dreq dwe  ill
    vt[0]  = '{32'h20080005, 2, 0, 1'b0, 1'b1, 7, OP_NEXT, 1, 0, 1'b0, 1'b0}; // addi, fetch stall
    vt[1]  = '{32'h10000014, 0, 0, 1'b1, 1'b0, 4, OP_BZ,   0, 0, 1'b0, 1'b0}; // beq taken, im1=20
    vt[2]  = '{32'h8C090010, 0, 3, 1'b0, 1'b0, 9, OP_NEXT, 1, 4, 1'b0, 1'b0}; // lw, dmem stall 3
    vt[3]  = '{32'hAC090010, 0, 0, 1'b1, 1'b1, 5, OP_NEXT, 0, 1, 1'b1, 1'b0}; // sw
    vt[4]  = '{32'h01095020, 1, 0, 1'b0, 1'b1, 6, OP_NEXT, 1, 0, 1'b0, 1'b0}; // add
    vt[5]  = '{32'h03E00008, 0, 0, 1'b1, 1'b0, 4, OP_JR,   0, 0, 1'b0, 1'b0}; // jr
    vt[6]  = '{32'h0C000100, 0, 0, 1'b0, 1'b0, 5, OP_JAL,  1, 0, 1'b0, 1'b0}; // jal
    vt[7]  = '{32'h08000040, 0, 1, 1'b1, 1'b1, 4, OP_J,    0, 0, 1'b0, 1'b0}; // j
    vt[8]  = '{32'h1C000003, 0, 0, 1'b0, 1'b1, 4, OP_BG,   0, 0, 1'b0, 1'b0}; // bgtz
    vt[9]  = '{32'h10000014, 0, 0, 1'b0, 1'b0, 4, OP_BZ,   0, 0, 1'b0, 1'b0}; // beq not taken
    vt[10] = '{32'hF8000000, 0, 0, 1'b1, 1'b0, 4, OP_NEXT, 0, 0, 1'b0, 1'b1}; // unknown 0x3E

    // reset held for 3 cycles
    rest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst imem_req", imem_req, 1'b0);
    chk("rst pc_op", pc_op, OP_HOLD);
    chk("rst retired", retired, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst outputs", {dmem_req, dmem_we, reg_we, zero, great, halted, illegal}, 7'd0);
    rest = 1'b1;
    #1;
    chk("idle imem_req", imem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("fetch imem_req", imem_req, 1'b1);
    chk("fetch pc_op", pc_op, OP_HOLD);
    chk("fetch retired", retired, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_instr(vt[i], i, i);
    end

    // halt: DECODE -> PCUPD (HOLD) -> HALT, not retired
    begin
      int   hc = 0;
      logic st = 1'b0;
      logic seen = 1'b0;
      logic hold_ok = 1'b1;
      for (int t = 0; t < 30 && !seen; t++) begin
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        if (imem_req) begin
          st         = 1'b1;
          imem_ack   = 1'b1;
          imem_rdata = 32'hFC000000;
        end
        if (st) hc++;
        if (pc_op !== OP_HOLD) hold_ok = 1'b0;
        if (halted) seen = 1'b1;
      end
      chk("halt reached", seen, 1'b1);
      chk("halt cycles", hc, 4);
      chk("halt pc_op hold", hold_ok, 1'b1);
      imem_ack = 1'b0;
    end

    // parked in HALT; stray acks must be ignored
    begin
      logic park_ok = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        imem_ack = t[0];
        dmem_ack = ~t[0];
        if (pc_op !== OP_HOLD || imem_req !== 1'b0 || dmem_req !== 1'b0 ||
            reg_we !== 1'b0 || halted !== 1'b1) park_ok = 1'b0;
      end
      chk("halt parked", park_ok, 1'b1);
      chk("halt retired", retired, 32'd11);
      chk("halt illegal", illegal, 1'b1);
    end

    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rest = 1'b0;
    #1;
    chk("rst2 halted", halted, 1'b0);
    chk("rst2 illegal", illegal, 1'b0);
    chk("rst2 retired", retired, 32'd0);
    repeat (2) @(negedge clk);
    rest = 1'b1;
    #1;
    chk("rst2 idle", imem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("rst2 fetch", imem_req, 1'b1);

    run_instr(vt[7], 7, 0);
    run_instr(vt[4], 4, 1);

    // reset pulled in the middle of MEM
    begin
      logic in_mem = 1'b0;
      for (int t = 0; t < 20 && !in_mem; t++) begin
        @(negedge clk);
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        if (dmem_req) in_mem = 1'b1;
        else if (imem_req) begin
          imem_ack   = 1'b1;
          imem_rdata = 32'h8C090010;
        end
      end
      chk("mid mem reached", in_mem, 1'b1);
      chk("mid retired before", retired, 32'd2);
      #2;
      rest = 1'b0;
      #1;
      chk("mid dmem_req", dmem_req, 1'b0);
      chk("mid retired", retired, 32'd0);
      chk("mid pc_op", pc_op, OP_HOLD);
      chk("mid imem_req", imem_req, 1'b0);
      @(negedge clk);
      rest = 1'b1;
      #1;
      chk("mid idle", imem_req, 1'b0);
      @(posedge clk);
      #1;
      chk("mid fetch", imem_req, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
